hex_tx_sequencer: RTL and testbench
===================================

HEX_TX_SEQUENCER -- requirements
Module: hex_tx_sequencer

Interface
REQ-001 The block SHALL have parameter SEP_CHAR, default 8'h20, the ASCII separator sent after each byte.
REQ-002 The block SHALL have parameter BYTES_PER_LINE, default 16, the bytes per line (range 1..255); it is used only when HEX_TX_NEWLINE_EN is defined.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, 8 bits: the byte to be dumped as hex.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port tx_data, output, 8 bits: the ASCII character presented to the UART transmitter.
REQ-009 The block SHALL have port tx_start, output, 1 bit: a one-cycle pulse that starts a UART transmission of tx_data.
REQ-010 The block SHALL have port tx_done_tick, input, 1 bit: a one-cycle pulse from the UART transmitter when the character has completed.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL transfer a byte only when in_valid and in_ready are both high on a rising edge; in_data is latched into an internal register on that edge.
REQ-013 in_ready SHALL be high exactly when the state is IDLE; in_valid while the block is busy SHALL be ignored (no queuing).
REQ-014 The FSM SHALL have the states IDLE, SEND and WAIT, plus a character index (HI, LO, SEP, CR, LF) that selects the current character.
REQ-015 IDLE -> SEND on handshake, with index=HI; SEND -> WAIT after exactly one cycle; WAIT -> SEND (next index) or IDLE on tx_done_tick.
REQ-016 tx_start SHALL be high for exactly the one cycle spent in SEND; tx_data SHALL be registered and stable from SEND until the next SEND.
REQ-017 Nibble conversion: values 0..9 SHALL map to 8'h30..8'h39, and values 10..15 SHALL map to 8'h41..8'h46 (uppercase); no other codes can occur.
REQ-018 The character order per byte SHALL be: HI (in_data[7:4]), LO (in_data[3:0]), then the terminator per REQ-026/027.
REQ-019 tx_done_tick SHALL be ignored in IDLE and SEND; a tick coincident with the SEND cycle SHALL NOT advance the index.
REQ-020 Latency: tx_start for HI SHALL assert on the first cycle after the handshake edge (SEND entered on that edge).
REQ-021 After the last character's tx_done_tick the block SHALL return to IDLE, with in_ready high on the next cycle; back-to-back bytes therefore incur one idle cycle between them.

Reset
REQ-022 Asserting reset at any time, including mid-sequence, SHALL force state=IDLE, index=HI, line counter=0, latched byte=8'h00 immediately (asynchronous).
REQ-023 During and after reset, the outputs SHALL be tx_start=0, tx_data=8'h00, busy=0 and in_ready=1.
REQ-024 A character aborted by reset SHALL NOT be resumed, and a stale tx_done_tick after reset SHALL be ignored per REQ-019.
REQ-025 Release of reset SHALL require no extra cycles; a handshake on the first edge after deassertion SHALL be accepted.

Configuration
REQ-026 Without HEX_TX_NEWLINE_EN, every byte SHALL be followed by SEP_CHAR only (3 characters per byte) and no line counter SHALL exist.
REQ-027 With HEX_TX_NEWLINE_EN defined, an 8-bit line counter SHALL count completed bytes; the byte that makes the count equal to BYTES_PER_LINE SHALL be followed by CR (8'h0D) then LF (8'h0A) instead of SEP_CHAR, and the counter SHALL wrap to 0.
REQ-028 With HEX_TX_NEWLINE_EN defined, the counter SHALL increment on the handshake, and the CR/LF decision SHALL be fixed at that moment.

Verification
REQ-029 The bench SHALL send in_data=8'h3C with the UART model acking each character after 10 cycles -> tx_data sequence 8'h33, 8'h43, 8'h20 with three tx_start pulses, then in_ready=1.
REQ-030 The bench SHALL send 8'h00 then 8'hFF back-to-back -> 30 30 20 46 46 20, with in_valid held high during busy not duplicating any byte.
REQ-031 The bench SHALL pulse tx_done_tick in the SEND cycle and in IDLE -> no index advance and no extra tx_start.
REQ-032 The bench SHALL assert reset while WAIT for LO -> tx_start=0, tx_data=8'h00, busy=0 immediately; the next byte 8'hA5 -> 41 35 20.
REQ-033 The bench SHALL build with HEX_TX_NEWLINE_EN and BYTES_PER_LINE=2 and send 01, 02, 03 -> 30 31 20, 30 32 0D 0A, 30 33 20.
REQ-034 The bench SHALL build without the macro and send 17 bytes -> no 8'h0D/8'h0A emitted, and SEP_CHAR after every byte.

Source files
------------

// File: rtl/hex_tx_sequencer.sv
// -----------------------------------------------------------------------------
// hex_tx_sequencer
//
// Turns each accepted byte into printable hex text for a UART transmitter:
// the high nibble, the low nibble, then a terminator character. Every
// character is handed to the transmitter with a one-cycle tx_start pulse and
// the block waits for tx_done_tick before presenting the next one.
//
// Build option:
//   HEX_TX_NEWLINE_EN - when defined, an 8-bit line counter counts accepted
//                       bytes and every BYTES_PER_LINE-th byte is terminated
//                       with CR LF instead of SEP_CHAR. When undefined, every
//                       byte is terminated with SEP_CHAR and no counter exists.
//
// Parameters:
//   SEP_CHAR        - separator character sent after each byte
//   BYTES_PER_LINE  - bytes per line (1..255), only used with the newline build
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   in_data[7:0]  in   byte to dump
//   in_valid      in   in_data is valid
//   in_ready      out  byte accepted this cycle (high exactly in IDLE)
//   tx_data[7:0]  out  character for the UART, registered
//   tx_start      out  one-cycle pulse starting a UART transmission
//   tx_done_tick  in   one-cycle pulse when the UART finished a character
//   busy          out  high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module hex_tx_sequencer #(
    parameter logic [7:0] SEP_CHAR       = 8'h20,
    parameter int         BYTES_PER_LINE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done_tick,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    typedef enum logic [2:0] {
        IDX_HI,
        IDX_LO,
        IDX_SEP,
        IDX_CR,
        IDX_LF
    } idx_t;

    if (BYTES_PER_LINE < 1 || BYTES_PER_LINE > 255) begin : g_bad_bytes_per_line
        $error("BYTES_PER_LINE must be in 1..255");
    end

    state_t     state_q, state_d;
    idx_t       idx_q, idx_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       newline;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        // 0..9 -> '0'..'9', 10..15 -> 'A'..'F' ('A' - 10 = 8'h37)
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] char_of(input idx_t idx, input logic [7:0] b);
        logic [7:0] c;
        case (idx)
            IDX_HI:  c = hex_char(b[7:4]);
            IDX_LO:  c = hex_char(b[3:0]);
            IDX_CR:  c = 8'h0D;
            IDX_LF:  c = 8'h0A;
            default: c = SEP_CHAR;
        endcase
        return c;
    endfunction

`ifdef HEX_TX_NEWLINE_EN
    localparam logic [7:0] LINE_LEN = 8'(BYTES_PER_LINE);

    logic [7:0] line_cnt_q, line_cnt_d;
    logic       nl_q, nl_d;

    // The CR/LF decision is taken at the handshake and held for the whole
    // byte, so the terminator never depends on later counter activity.
    always_comb begin
        line_cnt_d = line_cnt_q;
        nl_d       = nl_q;
        if (state_q == ST_IDLE && in_valid) begin
            if (line_cnt_q + 8'd1 == LINE_LEN) begin
                line_cnt_d = 8'd0;
                nl_d       = 1'b1;
            end else begin
                line_cnt_d = line_cnt_q + 8'd1;
                nl_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_cnt_q <= 8'd0;
            nl_q       <= 1'b0;
        end else begin
            line_cnt_q <= line_cnt_d;
            nl_q       <= nl_d;
        end
    end

    assign newline = nl_q;
`else
    assign newline = 1'b0;
`endif

    always_comb begin
        idx_t next_idx;
        logic last;

        state_d   = state_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        tx_data_d = tx_data_q;
        next_idx  = IDX_HI;
        last      = 1'b0;

        // Next character after the one just completed; SEP and LF end a byte.
        case (idx_q)
            IDX_HI:  next_idx = IDX_LO;
            IDX_LO:  next_idx = newline ? IDX_CR : IDX_SEP;
            IDX_CR:  next_idx = IDX_LF;
            default: last     = 1'b1;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_SEND;
                    idx_d     = IDX_HI;
                    byte_d    = in_data;
                    tx_data_d = char_of(IDX_HI, in_data);
                end
            end
            ST_SEND: begin
                // A done tick here belongs to nothing we started; ignore it.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    if (last) begin
                        state_d = ST_IDLE;
                        idx_d   = IDX_HI;
                    end else begin
                        state_d   = ST_SEND;
                        idx_d     = next_idx;
                        tx_data_d = char_of(next_idx, byte_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_HI;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_HI;
            byte_q    <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = (state_q == ST_SEND);
    assign busy     = (state_q != ST_IDLE);
    assign in_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_hex_tx_sequencer.sv
module tb_hex_tx_sequencer;

    localparam int BPL = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done_tick;
    logic       busy;

    logic uart_tick = 1'b0;
    logic man_tick  = 1'b0;
    bit   uart_en   = 1'b1;
    int   ucnt      = 0;

    assign tx_done_tick = uart_tick | man_tick;

    always #5 clk = ~clk;

    hex_tx_sequencer #(
        .SEP_CHAR      (8'h20),
        .BYTES_PER_LINE(BPL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done_tick(tx_done_tick),
        .busy        (busy)
    );

    // UART stand-in: acknowledges each started character about 10 cycles later.
    always @(negedge clk) begin
        if (uart_tick) uart_tick <= 1'b0;
        if (tx_start && uart_en) begin
            ucnt <= 10;
        end else if (ucnt > 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) uart_tick <= 1'b1;
        end
    end

    // Character capture plus a tx_data stability monitor while busy.
    logic [7:0] cap [0:1023];
    int         cap_n      = 0;
    logic [7:0] last_start = 8'h00;
    int         unstable   = 0;

    always @(negedge clk) begin
        if (tx_start) begin
            if (cap_n < 1024) cap[cap_n] <= tx_data;
            cap_n      <= cap_n + 1;
            last_start <= tx_data;
        end else if (busy && tx_data != last_start) begin
            unstable <= unstable + 1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int rd       = 0;
    int mcnt     = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [7:0] nib);
        int v;
        v = int'(nib);
        return 8'((v < 10) ? (48 + v) : (65 + v - 10));
    endfunction

    // Reference: what the text dump of one accepted byte should look like.
    task automatic model_byte(input logic [7:0] b);
        exp_q.push_back(hexc({4'h0, b[7:4]}));
        exp_q.push_back(hexc({4'h0, b[3:0]}));
`ifdef HEX_TX_NEWLINE_EN
        mcnt++;
        if (mcnt == BPL) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            mcnt = 0;
        end else begin
            exp_q.push_back(8'h20);
        end
`else
        exp_q.push_back(8'h20);
`endif
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        man_tick = 1'b0;
        step();
        step();
        reset = 1'b0;
        mcnt  = 0;
        rd    = cap_n;
        exp_q.delete();
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        chk(name, in_ready, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || ucnt != 0) && n < 400) begin
            step();
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready("ready_before_send");
        in_data  = b;
        in_valid = 1'b1;
        model_byte(b);
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_stream(input string name);
        chk({name, "_len"}, cap_n - rd, exp_q.size());
        for (int i = 0; i < exp_q.size() && rd + i < cap_n; i++)
            chk(name, cap[rd + i], exp_q[i]);
        rd = cap_n;
        exp_q.delete();
    endtask

    initial begin
        int base;
        int n;
        int crlf;
        int seps;

        vecs[0] = '{8'h3C, 8'h33, 8'h43};
        vecs[1] = '{8'h00, 8'h30, 8'h30};
        vecs[2] = '{8'hFF, 8'h46, 8'h46};
        vecs[3] = '{8'hA5, 8'h41, 8'h35};
        vecs[4] = '{8'h9A, 8'h39, 8'h41};
        vecs[5] = '{8'h0F, 8'h30, 8'h46};
        vecs[6] = '{8'hF0, 8'h46, 8'h30};
        vecs[7] = '{8'h7E, 8'h37, 8'h45};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Handshake on the very first edge after reset release; HI goes out next cycle.
        in_data  = 8'h3C;
        in_valid = 1'b1;
        reset    = 1'b0;
        model_byte(8'h3C);
        step();
        chk("latency_tx_start", tx_start, 1);
        chk("latency_tx_data", tx_data, 8'h33);
        chk("latency_in_ready", in_ready, 0);
        in_valid = 1'b0;
        step();
        chk("start_one_cycle", tx_start, 0);
        wait_idle("byte_3c_idle");
        check_stream("byte_3c");
        chk("byte_3c_ready", in_ready, 1);

        // Back-to-back with in_valid held high across the busy period.
        wait_ready("b2b_ready");
        in_data  = 8'h00;
        in_valid = 1'b1;
        model_byte(8'h00);
        step();
        in_data = 8'hFF;
        n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        chk("b2b_idle_gap", in_ready, 1);
        chk("b2b_no_dup", cap_n - rd, 3 + ((exp_q.size() > 3) ? 2 : 0) - ((exp_q.size() > 3) ? 1 : 0));
        model_byte(8'hFF);
        step();
        chk("b2b_second_taken", busy, 1);
        in_valid = 1'b0;
        wait_idle("b2b_idle");
        check_stream("b2b");

        // Done ticks in IDLE and in SEND must not advance anything.
        uart_en = 1'b0;
        step();
        man_tick = 1'b1;
        step();
        man_tick = 1'b0;
        chk("idle_tick_busy", busy, 0);
        chk("idle_tick_nostart", cap_n - rd, 0);
        wait_ready("tick_ready");
        in_data  = 8'h5A;
        in_valid = 1'b1;
        model_byte(8'h5A);
        step();
        chk("tick_send_start", tx_start, 1);
        man_tick = 1'b1;
        in_valid = 1'b0;
        step();
        man_tick = 1'b0;
        chk("tick_send_no_restart", tx_start, 0);
        chk("tick_send_busy", busy, 1);
        step();
        step();
        chk("tick_send_noadv", cap_n - rd, 1);
        chk("tick_send_hold", tx_data, 8'h35);
        man_tick = 1'b1;
        uart_en  = 1'b1;
        step();
        man_tick = 1'b0;
        chk("tick_wait_advance", tx_start, 1);
        chk("tick_wait_lo", tx_data, 8'h41);
        wait_idle("tick_idle");
        check_stream("tick_seq");

        // Reset while waiting for the LO character to finish.
        send_byte(8'h3C);
        n = 0;
        while (cap_n - rd < 2 && n < 100) begin
            step();
            n++;
        end
        chk("abort_lo_sent", cap_n - rd, 2);
        step();
        chk("abort_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_tx_start", tx_start, 0);
        chk("abort_tx_data", tx_data, 8'h00);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_lo_char", cap[rd + 1], 8'h43);
        rd = cap_n;
        exp_q.delete();
        mcnt = 0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("stale_tick_busy", busy, 0);
        chk("stale_tick_nostart", cap_n - rd, 0);
        send_byte(8'hA5);
        wait_idle("after_abort_idle");
        check_stream("after_abort");

        // 17 bytes: table vectors then random bytes against the model.
        do_reset();
        base = cap_n;
        for (int i = 0; i < 8; i++) begin
            send_byte(vecs[i].din);
            wait_idle("vec_idle");
            chk("vec_hi", cap[rd], vecs[i].hi);
            chk("vec_lo", cap[rd + 1], vecs[i].lo);
            check_stream("vec_stream");
        end
        for (int i = 0; i < 9; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            wait_idle("rand_idle");
            check_stream("rand_stream");
        end
`ifndef HEX_TX_NEWLINE_EN
        crlf = 0;
        seps = 0;
        for (int i = base; i < cap_n; i++) begin
            if (cap[i] == 8'h0D || cap[i] == 8'h0A) crlf++;
            if (cap[i] == 8'h20) seps++;
        end
        chk("no_crlf", crlf, 0);
        chk("sep_count", seps, 17);
        chk("char_count", cap_n - base, 51);
`else
        do_reset();
        send_byte(8'h01);
        wait_idle("nl_idle1");
        send_byte(8'h02);
        wait_idle("nl_idle2");
        send_byte(8'h03);
        wait_idle("nl_idle3");
        exp_q = '{8'h30, 8'h31, 8'h20, 8'h30, 8'h32, 8'h0D, 8'h0A, 8'h30, 8'h33, 8'h20};
        check_stream("newline");
`endif

        chk("tx_data_stable", unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
